// File: rtl/ms_sampler_pkg.sv
// ms_sampler_pkg -- shared types and constants for the ms_sampler_n block.
//   ms_sampler_sections_t : SECTION_A (sample) / SECTION_B (offer)
//   DROP_W                : width of the saturating drop counter
//   ch_width(n)           : channel index width, max(1, clog2(n))
package ms_sampler_pkg;

   typedef enum logic {
      SECTION_A = 1'b0,
      SECTION_B = 1'b1
   } ms_sampler_sections_t;

   localparam int DROP_W = 8;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ms_sampler_n_if.sv
// ms_sampler_n_if -- bundles the sampler's slave-side inputs and master-side
// offer outputs.
//   s_in/s_in_sync/shared_in : slave data, per-channel present flags, gate
//   s_out/s_out_valid/s_out_ready/s_out_ch : master offer handshake
//   succ/drop_cnt            : last-offer status, saturating drop count
// Modports: slave = the sampler itself, master = the surrounding environment.
interface ms_sampler_n_if
   import ms_sampler_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NUM_CH = 4
);
   localparam int CH_W = ch_width(NUM_CH);

   logic [NUM_CH*DATA_W-1:0] s_in;
   logic [NUM_CH-1:0]        s_in_sync;
   logic                     shared_in;
   logic [DATA_W-1:0]        s_out;
   logic                     s_out_valid;
   logic                     s_out_ready;
   logic [CH_W-1:0]          s_out_ch;
   logic                     succ;
   logic [DROP_W-1:0]        drop_cnt;

   modport slave (
      input  s_in, s_in_sync, shared_in, s_out_ready,
      output s_out, s_out_valid, s_out_ch, succ, drop_cnt
   );

   modport master (
      output s_in, s_in_sync, shared_in, s_out_ready,
      input  s_out, s_out_valid, s_out_ch, succ, drop_cnt
   );

endinterface

// File: rtl/ms_rr_pick.sv
// ms_rr_pick -- combinational round-robin channel picker.
//   sync_i  : per-channel request vector
//   ptr_i   : channel searched first (must be < NUM_CH)
//   found_o : any request set
//   idx_o   : first requesting channel at or above ptr_i, wrapping to 0
module ms_rr_pick
   import ms_sampler_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CH_W   = ch_width(NUM_CH)
) (
   input  logic [NUM_CH-1:0] sync_i,
   input  logic [CH_W-1:0]   ptr_i,
   output logic              found_o,
   output logic [CH_W-1:0]   idx_o
);

   int c;

   // Walk from the farthest candidate back to ptr_i so the nearest hit is
   // written last and wins.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      c       = 0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         c = int'(ptr_i) + k;
         if (c >= NUM_CH) c = c - NUM_CH;
         if (sync_i[c]) begin
            found_o = 1'b1;
            idx_o   = CH_W'(c);
         end
      end
   end

endmodule

// File: rtl/ms_sampler_n.sv
// ms_sampler_n -- samples one of NUM_CH slave channels round-robin and
// offers it on a valid/ready master port, one offer at a time.
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : ms_sampler_n_if.slave (slave inputs, master offer, status)
// Optional feature macro MS_SAMPLER_TIMEOUT_EN: an offer not accepted within
// TIMEOUT cycles is dropped and counted in drop_cnt (saturating). Without it
// an offer waits indefinitely and drop_cnt is tied to 0.
module ms_sampler_n
   import ms_sampler_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int NUM_CH  = 4,
   parameter int TIMEOUT = 15
) (
   input logic           clk,
   input logic           rst,
   ms_sampler_n_if.slave bus
);

   localparam int CH_W = ch_width(NUM_CH);

   ms_sampler_sections_t state_q, state_d;
   logic [DATA_W-1:0]    data_q, data_d;
   logic [CH_W-1:0]      ch_q, ch_d;
   logic [CH_W-1:0]      ptr_q, ptr_d;
   logic                 succ_q, succ_d;

   logic                 found;
   logic [CH_W-1:0]      idx;

`ifdef MS_SAMPLER_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0]     tmo_q, tmo_d;
   logic [DROP_W-1:0] drop_q, drop_d;
`endif

   ms_rr_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick (
      .sync_i  (bus.s_in_sync),
      .ptr_i   (ptr_q),
      .found_o (found),
      .idx_o   (idx)
   );

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      ch_d    = ch_q;
      ptr_d   = ptr_q;
      succ_d  = succ_q;
`ifdef MS_SAMPLER_TIMEOUT_EN
      tmo_d   = tmo_q;
      drop_d  = drop_q;
`endif
      case (state_q)
         SECTION_A: begin
            if (!bus.shared_in && found) begin
               state_d = SECTION_B;
               data_d  = bus.s_in[int'(idx)*DATA_W +: DATA_W];
               ch_d    = idx;
               // pointer moves past the winner; NUM_CH=1 keeps it at 0
               ptr_d   = (idx == CH_W'(NUM_CH - 1)) ? '0 : idx + 1'b1;
`ifdef MS_SAMPLER_TIMEOUT_EN
               tmo_d   = '0;
`endif
            end
         end
         SECTION_B: begin
            // ready on the final timeout cycle still counts as a transfer
            if (bus.s_out_ready) begin
               state_d = SECTION_A;
               succ_d  = 1'b1;
            end
`ifdef MS_SAMPLER_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) begin
               state_d = SECTION_A;
               succ_d  = 1'b0;
               if (drop_q != '1) drop_d = drop_q + 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
`endif
         end
         default: state_d = SECTION_A;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= SECTION_A;
         data_q  <= '0;
         ch_q    <= '0;
         ptr_q   <= '0;
         succ_q  <= 1'b0;
`ifdef MS_SAMPLER_TIMEOUT_EN
         tmo_q   <= '0;
         drop_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         ch_q    <= ch_d;
         ptr_q   <= ptr_d;
         succ_q  <= succ_d;
`ifdef MS_SAMPLER_TIMEOUT_EN
         tmo_q   <= tmo_d;
         drop_q  <= drop_d;
`endif
      end
   end

   assign bus.s_out       = data_q;
   assign bus.s_out_ch    = ch_q;
   assign bus.s_out_valid = (state_q == SECTION_B);
   assign bus.succ        = succ_q;
`ifdef MS_SAMPLER_TIMEOUT_EN
   assign bus.drop_cnt    = drop_q;
`else
   assign bus.drop_cnt    = '0;
`endif

endmodule

// File: tb/tb_ms_sampler_n.sv
// tb_ms_sampler_n -- self-checking bench for ms_sampler_n (4 channels, 32b).
// Directed table of {inputs, expected outputs}, hand sequences for timeout /
// indefinite wait, then randomized traffic against a behavioural model.
module tb_ms_sampler_n;

   localparam int DW = 32;
   localparam int NC = 4;
   localparam int TO = 15;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ms_sampler_n_if #(.DATA_W(DW), .NUM_CH(NC)) bus ();

   ms_sampler_n #(.DATA_W(DW), .NUM_CH(NC), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [3:0] sy, input logic sh, input logic rd);
      rst               = r;
      bus.s_in_sync     = sy;
      bus.shared_in     = sh;
      bus.s_out_ready   = rd;
   endtask

   typedef struct {
      logic        r;
      logic [3:0]  sync;
      logic        sh;
      logic        rdy;
      logic        vld;
      logic [31:0] out;
      logic [1:0]  ch;
      logic        succ;
   } vec_t;

   localparam logic [127:0] CH_DATA = {32'hCAFE0003, 32'h00001234, 32'hBEEF0001, 32'hD00D0000};

   vec_t tbl[22];

   // behavioural model
   bit          m_busy;
   int          m_ptr, m_ch, m_age, m_drop;
   logic [31:0] m_data;
   bit          m_succ;

   task automatic model_step(input logic r, input logic [3:0] sy, input logic sh,
                             input logic rd, input logic [127:0] sin);
      int c;
      if (!r) begin
         m_busy = 0; m_ptr = 0; m_ch = 0; m_age = 0; m_drop = 0; m_data = '0; m_succ = 0;
      end else if (!m_busy) begin
         if (!sh) begin
            for (int k = 0; k < NC; k++) begin
               c = (m_ptr + k) % NC;
               if (sy[c] && !m_busy) begin
                  m_busy = 1;
                  m_ch   = c;
                  m_data = sin[c*32 +: 32];
                  m_ptr  = (c + 1) % NC;
                  m_age  = 0;
               end
            end
         end
      end else if (rd) begin
         m_busy = 0;
         m_succ = 1;
      end else begin
`ifdef MS_SAMPLER_TIMEOUT_EN
         if (m_age == TO - 1) begin
            m_busy = 0;
            m_succ = 0;
            if (m_drop < 255) m_drop++;
         end else m_age++;
`endif
      end
   endtask

   initial begin
      int hi;
      int thr;
      logic [3:0]   rs;
      logic         rsh, rrd, rr;
      logic [127:0] rin;

      //             r  sync     sh rdy  vld out           ch succ
      tbl[0]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0,        2'd0, 1'b0};
      tbl[1]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, 32'h00001234, 2'd2, 1'b0};
      tbl[2]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 32'h00001234, 2'd2, 1'b1};
      tbl[3]  = '{1'b1, 4'b1001, 1'b0, 1'b0, 1'b1, 32'hCAFE0003, 2'd3, 1'b1};
      tbl[4]  = '{1'b1, 4'b1001, 1'b0, 1'b1, 1'b0, 32'hCAFE0003, 2'd3, 1'b1};
      tbl[5]  = '{1'b1, 4'b1001, 1'b0, 1'b0, 1'b1, 32'hD00D0000, 2'd0, 1'b1};
      tbl[6]  = '{1'b1, 4'b1001, 1'b0, 1'b1, 1'b0, 32'hD00D0000, 2'd0, 1'b1};
      tbl[7]  = '{1'b1, 4'b1001, 1'b0, 1'b0, 1'b1, 32'hCAFE0003, 2'd3, 1'b1};
      tbl[8]  = '{1'b1, 4'b1001, 1'b0, 1'b1, 1'b0, 32'hCAFE0003, 2'd3, 1'b1};
      for (int i = 9; i < 14; i++)
         tbl[i] = '{1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 32'hCAFE0003, 2'd3, 1'b1};
      tbl[14] = '{1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 32'hD00D0000, 2'd0, 1'b1};
      tbl[15] = '{1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 32'hD00D0000, 2'd0, 1'b1};
      tbl[16] = '{1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 32'hD00D0000, 2'd0, 1'b1};
      tbl[17] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 32'hD00D0000, 2'd0, 1'b1};
      tbl[18] = '{1'b1, 4'b1111, 1'b0, 1'b1, 1'b1, 32'hBEEF0001, 2'd1, 1'b1};
      tbl[19] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 32'hBEEF0001, 2'd1, 1'b1};
      tbl[20] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0,        2'd0, 1'b0};
      tbl[21] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0,        2'd0, 1'b0};

      bus.s_in = CH_DATA;
      drive(1'b0, 4'b0000, 1'b0, 1'b0);
      @(negedge clk);

      // directed table: inputs before an edge, outputs checked after it
      for (int i = 0; i < 22; i++) begin
         drive(tbl[i].r, tbl[i].sync, tbl[i].sh, tbl[i].rdy);
         @(negedge clk);
         chk($sformatf("tbl%0d_valid", i), 64'(bus.s_out_valid), 64'(tbl[i].vld));
         chk($sformatf("tbl%0d_out", i),   64'(bus.s_out),       64'(tbl[i].out));
         chk($sformatf("tbl%0d_ch", i),    64'(bus.s_out_ch),    64'(tbl[i].ch));
         chk($sformatf("tbl%0d_succ", i),  64'(bus.succ),        64'(tbl[i].succ));
         chk($sformatf("tbl%0d_drop", i),  64'(bus.drop_cnt),    64'd0);
      end

`ifdef MS_SAMPLER_TIMEOUT_EN
      // offer left unaccepted: valid for TIMEOUT cycles, then dropped
      drive(1'b1, 4'b0001, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 4'b0000, 1'b0, 1'b0);
      hi = 0;
      for (int t = 0; t < 40 && bus.s_out_valid; t++) begin
         hi++;
         @(negedge clk);
      end
      chk("tmo_valid_cycles", 64'(hi), 64'd15);
      chk("tmo_valid_low", 64'(bus.s_out_valid), 64'd0);
      chk("tmo_succ", 64'(bus.succ), 64'd0);
      chk("tmo_drop1", 64'(bus.drop_cnt), 64'd1);

      // ready arriving on the last timeout cycle still transfers
      drive(1'b1, 4'b0001, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 4'b0000, 1'b0, 1'b0);
      repeat (14) @(negedge clk);
      chk("tmo_edge_valid", 64'(bus.s_out_valid), 64'd1);
      drive(1'b1, 4'b0000, 1'b0, 1'b1);
      @(negedge clk);
      chk("tmo_edge_succ", 64'(bus.succ), 64'd1);
      chk("tmo_edge_valid_low", 64'(bus.s_out_valid), 64'd0);
      chk("tmo_edge_drop", 64'(bus.drop_cnt), 64'd1);

      // back-to-back drops saturate the counter
      drive(1'b1, 4'b0001, 1'b0, 1'b0);
      repeat (260 * 16) @(negedge clk);
      chk("drop_sat", 64'(bus.drop_cnt), 64'd255);
      drive(1'b0, 4'b0000, 1'b0, 1'b0);
      @(negedge clk);
      chk("drop_reset", 64'(bus.drop_cnt), 64'd0);
`else
      // without the timeout an offer waits as long as it takes
      drive(1'b1, 4'b0001, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 4'b0000, 1'b0, 1'b0);
      repeat (40) @(negedge clk);
      chk("wait_valid", 64'(bus.s_out_valid), 64'd1);
      chk("wait_drop", 64'(bus.drop_cnt), 64'd0);
      drive(1'b1, 4'b0000, 1'b0, 1'b1);
      @(negedge clk);
      chk("wait_succ", 64'(bus.succ), 64'd1);
      chk("wait_valid_low", 64'(bus.s_out_valid), 64'd0);
      hi = 0;
`endif

      // randomized traffic vs model; ready rate alternates so long stalls occur
      drive(1'b0, 4'b0000, 1'b0, 1'b0);
      model_step(1'b0, 4'b0000, 1'b0, 1'b0, bus.s_in);
      @(negedge clk);
      thr = 4;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         chk("rnd_valid", 64'(bus.s_out_valid), 64'(m_busy));
         chk("rnd_out",   64'(bus.s_out),       64'(m_data));
         chk("rnd_ch",    64'(bus.s_out_ch),    64'(m_ch));
         chk("rnd_succ",  64'(bus.succ),        64'(m_succ));
         chk("rnd_drop",  64'(bus.drop_cnt),    64'(m_drop));
         if (cyc % 200 == 199) thr = (thr == 0) ? 4 : 0;
         rin = {$urandom, $urandom, $urandom, $urandom};
         rs  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
         rsh = ($urandom_range(0, 3) == 0);
         rrd = ($urandom_range(0, 7) < thr);
         rr  = ($urandom_range(0, 63) != 0);
         bus.s_in = rin;
         drive(rr, rs, rsh, rrd);
         model_step(rr, rs, rsh, rrd, rin);
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
